// File: rtl/fetch_queue.sv
// Two-wide circular instruction queue between the fetch window and decode.
// Accepts up to two PC-tagged instructions per cycle and presents the two oldest to decode.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                programCounter,
    output logic [31:0]                requestPC1,
    output logic [31:0]                requestPC2,
    input  logic [31:0]                instruction1,
    input  logic [31:0]                instruction2,
    input  logic                       badData,
    output logic                       instructionConsumed1,
    output logic                       instructionConsumed2,
    output logic                       outValid1,
    output logic                       outValid2,
    output logic [31:0]                outInstruction1,
    output logic [31:0]                outInstruction2,
    output logic [31:0]                outPC1,
    output logic [31:0]                outPC2,
    input  logic                       decodeTake1,
    input  logic                       decodeTake2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [CW-1:0] free_s;
    logic [31:0]   pc_plus4_s;
    logic [PW-1:0] tail_plus1_s;
    logic [PW-1:0] head_plus1_s;
    logic          pop1_s, pop2_s;
    logic [CW-1:0] push_cnt_s, pop_cnt_s;

    assign pc_plus4_s   = programCounter + 32'd4;
    assign requestPC1   = programCounter;
    assign requestPC2   = pc_plus4_s;
    assign tail_plus1_s = tail_q + PW'(1);
    assign head_plus1_s = head_q + PW'(1);

    // Free space comes from the registered count only, so same-cycle pops give no credit.
    assign free_s               = CW'(DEPTH) - count_q;
    assign instructionConsumed1 = reset & ~redirect & (free_s >= CW'(1));
    assign instructionConsumed2 = instructionConsumed1 & (free_s >= CW'(2)) & ~badData;

    assign outValid1 = (count_q >= CW'(1));
    assign outValid2 = (count_q >= CW'(2));
    assign pop1_s    = decodeTake1 & outValid1;
    assign pop2_s    = pop1_s & decodeTake2 & outValid2;

    assign push_cnt_s = CW'(instructionConsumed1) + CW'(instructionConsumed2);
    assign pop_cnt_s  = CW'(pop1_s) + CW'(pop2_s);

    assign outInstruction1 = outValid1 ? instr_mem_q[head_q]       : 32'd0;
    assign outInstruction2 = outValid2 ? instr_mem_q[head_plus1_s] : 32'd0;
    assign outPC1          = outValid1 ? pc_mem_q[head_q]          : 32'd0;
    assign outPC2          = outValid2 ? pc_mem_q[head_plus1_s]    : 32'd0;
    assign count           = count_q;

    // Pointer and occupancy next-state; redirect discards everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_cnt_s[PW-1:0];
            tail_d  = tail_q + push_cnt_s[PW-1:0];
            count_d = count_q + push_cnt_s - pop_cnt_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; not reset, validity is carried by count alone.
    always_ff @(posedge clock) begin
        if (instructionConsumed1) begin
            pc_mem_q[tail_q]    <= programCounter;
            instr_mem_q[tail_q] <= instruction1;
        end
        if (instructionConsumed2) begin
            pc_mem_q[tail_plus1_s]    <= pc_plus4_s;
            instr_mem_q[tail_plus1_s] <= instruction2;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=8) plus a wrap-around stream check.
module tb_fetch_queue;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] programCounter;
    logic [31:0] requestPC1, requestPC2;
    logic [31:0] instruction1, instruction2;
    logic        badData;
    logic        instructionConsumed1, instructionConsumed2;
    logic        outValid1, outValid2;
    logic [31:0] outInstruction1, outInstruction2;
    logic [31:0] outPC1, outPC2;
    logic        decodeTake1, decodeTake2;
    logic [3:0]  count;

    int total;
    int bad;

    fetch_queue #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset), .redirect(redirect),
        .programCounter(programCounter),
        .requestPC1(requestPC1), .requestPC2(requestPC2),
        .instruction1(instruction1), .instruction2(instruction2),
        .badData(badData),
        .instructionConsumed1(instructionConsumed1),
        .instructionConsumed2(instructionConsumed2),
        .outValid1(outValid1), .outValid2(outValid2),
        .outInstruction1(outInstruction1), .outInstruction2(outInstruction2),
        .outPC1(outPC1), .outPC2(outPC2),
        .decodeTake1(decodeTake1), .decodeTake2(decodeTake2),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        redir;
        logic        bd;
        logic        t1;
        logic        t2;
        logic [31:0] pc;
        logic        exp_c1;
        logic        exp_c2;
        logic [3:0]  exp_cnt;
        logic [31:0] exp_pc1;
        logic [31:0] exp_pc2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic redir, input logic bd, input logic t1,
                       input logic t2, input logic [31:0] pc, input logic c1, input logic c2,
                       input logic [3:0] cnt, input logic [31:0] p1, input logic [31:0] p2);
        vec_t v;
        v.rst = rst; v.redir = redir; v.bd = bd; v.t1 = t1; v.t2 = t2; v.pc = pc;
        v.exp_c1 = c1; v.exp_c2 = c2; v.exp_cnt = cnt; v.exp_pc1 = p1; v.exp_pc2 = p2;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic redir, input logic bd,
                         input logic t1, input logic t2, input logic [31:0] pc);
        reset          = rst;
        redirect       = redir;
        badData        = bd;
        decodeTake1    = t1;
        decodeTake2    = t2;
        programCounter = pc;
        instruction1   = pc + 32'h1000_0000;
        instruction2   = pc + 32'h1000_0004;
    endtask

    logic [31:0] exp_next;
    int          pushed;
    int          popped;
    logic [31:0] pc_ramp;

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100);

        // Reset state.
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_c1", {31'd0, instructionConsumed1}, 32'd0);
        check("rst_c2", {31'd0, instructionConsumed2}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_valid1", {31'd0, outValid1}, 32'd0);
        check("rst_pc1", outPC1, 32'd0);
        check("rst_instr1", outInstruction1, 32'd0);

        //   rst    redir  bad    t1     t2     pc            c1     c2     cnt    pc1           pc2
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 4'd2, 32'h100, 32'h104);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 1'b1, 4'd4, 32'h100, 32'h104);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 1'b1, 4'd6, 32'h100, 32'h104);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h118, 1'b1, 1'b1, 4'd8, 32'h100, 32'h104);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h120, 1'b0, 1'b0, 4'd8, 32'h100, 32'h104);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 1'b0, 4'd6, 32'h108, 32'h10C);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h120, 1'b1, 1'b1, 4'd8, 32'h108, 32'h10C);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h128, 1'b0, 1'b0, 4'd7, 32'h10C, 32'h110);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h128, 1'b1, 1'b0, 4'd8, 32'h10C, 32'h110);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h130, 1'b0, 1'b0, 4'd6, 32'h114, 32'h118);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h130, 1'b1, 1'b1, 4'd8, 32'h114, 32'h118);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h138, 1'b0, 1'b0, 4'd6, 32'h11C, 32'h120);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h138, 1'b1, 1'b0, 4'd5, 32'h124, 32'h128);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 4'd0, 32'h000, 32'h000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 4'd2, 32'h200, 32'h204);
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h208, 1'b1, 1'b0, 4'd2, 32'h204, 32'h208);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20C, 1'b1, 1'b1, 4'd3, 32'h208, 32'h20C);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 4'd0, 32'h000, 32'h000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 4'd2, 32'h300, 32'h304);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].redir, vecs[i].bd, vecs[i].t1, vecs[i].t2, vecs[i].pc);
            #1;
            check($sformatf("v%0d_c1", i), {31'd0, instructionConsumed1}, {31'd0, vecs[i].exp_c1});
            check($sformatf("v%0d_c2", i), {31'd0, instructionConsumed2}, {31'd0, vecs[i].exp_c2});
            check($sformatf("v%0d_req2", i), requestPC2, vecs[i].pc + 32'd4);
            @(posedge clock); #1;
            check($sformatf("v%0d_count", i), {28'd0, count}, {28'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d_pc1", i), outPC1, vecs[i].exp_pc1);
            check($sformatf("v%0d_pc2", i), outPC2, vecs[i].exp_pc2);
            check($sformatf("v%0d_val1", i), {31'd0, outValid1}, {31'd0, (vecs[i].exp_cnt >= 4'd1)});
            check($sformatf("v%0d_val2", i), {31'd0, outValid2}, {31'd0, (vecs[i].exp_cnt >= 4'd2)});
            check($sformatf("v%0d_ins1", i), outInstruction1,
                  (vecs[i].exp_cnt >= 4'd1) ? vecs[i].exp_pc1 + 32'h1000_0000 : 32'd0);
            check($sformatf("v%0d_ins2", i), outInstruction2,
                  (vecs[i].exp_cnt >= 4'd2) ? vecs[i].exp_pc2 + 32'h1000_0000 : 32'd0);
        end

        // Wrap-around stream: PC ramp from 0, window advances by accepted slots.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clock); #1;
        exp_next = 32'd0;
        pushed   = 0;
        popped   = 0;
        pc_ramp  = 32'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pc_ramp);
            #1;
            if (outValid1) begin
                check("wrap_pc1", outPC1, exp_next);
                exp_next = exp_next + 32'd4;
                popped++;
                if (outValid2) begin
                    check("wrap_pc2", outPC2, exp_next);
                    exp_next = exp_next + 32'd4;
                    popped++;
                end
            end
            if (instructionConsumed1) begin
                pc_ramp = pc_ramp + 32'd4;
                pushed++;
            end
            if (instructionConsumed2) begin
                pc_ramp = pc_ramp + 32'd4;
                pushed++;
            end
            @(posedge clock); #1;
        end
        check("wrap_pushed", pushed, 32'd40);
        check("wrap_popped", popped, 32'd38);
        check("wrap_count", {28'd0, count}, pushed - popped);
        check("wrap_head_pc", outPC1, 32'd152);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
